// File: rtl/health_bar_animator.sv
// Two-player health-bar overlay: lagging damage trail (hold, then drain), blinking KO box, registered RGB565 pixel.
// Optional macro LOW_HEALTH_FLASH_EN makes a low-health yellow segment alternate with white.
module health_bar_animator #(
    parameter int HW          = 9,
    parameter int MAX_HEALTH  = 300,
    parameter int BAR_LEN     = 40,
    parameter int BAR_Y       = 2,
    parameter int BAR_H       = 5,
    parameter int CLK_DIV     = 2_500_000,
    parameter int HOLD_TICKS  = 10,
    parameter int DRAIN_STEP  = 2,
    parameter int BLINK_TICKS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [HW-1:0] curr_health_l,
    input  logic [HW-1:0] curr_health_r,
    input  logic [12:0]   pixel_index,
    output logic [15:0]   oled_colour,
    output logic [HW-1:0] final_health_l,
    output logic [HW-1:0] final_health_r,
    output logic          ko_l,
    output logic          ko_r,
    output logic          anim_busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam int BLK_W  = $clog2(BLINK_TICKS + 1);
    localparam int PW     = HW + $clog2(BAR_LEN + 1);

    localparam logic [15:0] C_WHITE  = 16'hFFFF;
    localparam logic [15:0] C_RED    = 16'hF800;
    localparam logic [15:0] C_YELLOW = 16'hFFE0;
    localparam logic [15:0] C_GREY   = 16'h2104;

    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick;
    logic [HW-1:0]     h [2];
    logic [1:0]        st_q [2];
    logic [1:0]        st_d [2];
    logic [HW-1:0]     trail_q [2];
    logic [HW-1:0]     trail_d [2];
    logic [HW-1:0]     hprev_q [2];
    logic [HW-1:0]     hprev_d [2];
    logic [HOLD_W-1:0] hold_q [2];
    logic [HOLD_W-1:0] hold_d [2];
    logic [1:0]        ko_q, ko_d;
    logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic              any_ko;
    logic              lh_phase;
    logic [15:0]       oled_q, oled_d;
    logic [12:0]       px, py, bar_i;
    logic              side, in_rows, in_bar;

    function automatic logic [HW-1:0] clamp(input logic [HW-1:0] v);
        return (v > HW'(MAX_HEALTH)) ? HW'(MAX_HEALTH) : v;
    endfunction

    function automatic logic [12:0] fill(input logic [HW-1:0] v);
        logic [PW-1:0] prod;
        prod = PW'(v) * PW'(BAR_LEN);
        return 13'(prod / PW'(MAX_HEALTH));
    endfunction

    // "KO" glyph inside the box: K at x43..47, O at x48..52, rows y3..8.
    function automatic logic ko_glyph(input logic [12:0] x, input logic [12:0] y);
        logic [9:0] row;
        logic [3:0] col;
        case (y)
            13'd3:   row = 10'b10001_01110;
            13'd4:   row = 10'b10010_10001;
            13'd5:   row = 10'b11100_10001;
            13'd6:   row = 10'b11100_10001;
            13'd7:   row = 10'b10010_10001;
            13'd8:   row = 10'b10001_01110;
            default: row = 10'b0;
        endcase
        col = 4'(x - 13'd43);
        return (x >= 13'd43 && x <= 13'd52) ? row[4'd9 - col] : 1'b0;
    endfunction

    assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
    assign any_ko = |ko_q;

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        h[0]  = clamp(curr_health_l);
        h[1]  = clamp(curr_health_r);
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            st_d[s]    = st_q[s];
            trail_d[s] = trail_q[s];
            hprev_d[s] = hprev_q[s];
            hold_d[s]  = hold_q[s];
            ko_d[s]    = ko_q[s];
            if (tick) begin
                hprev_d[s] = h[s];
                if (h[s] > trail_q[s]) begin
                    trail_d[s] = h[s];
                    st_d[s]    = ST_IDLE;
                end else begin
                    case (st_q[s])
                        ST_IDLE: begin
                            if (h[s] < trail_q[s]) begin
                                st_d[s]   = ST_HOLD;
                                hold_d[s] = HOLD_W'(HOLD_TICKS - 1);
                            end
                        end
                        ST_HOLD: begin
                            if (h[s] < hprev_q[s])
                                hold_d[s] = HOLD_W'(HOLD_TICKS - 1);
                            else if (hold_q[s] == '0)
                                st_d[s] = ST_DRAIN;
                            else
                                hold_d[s] = hold_q[s] - 1'b1;
                        end
                        ST_DRAIN: begin
                            // h <= trail here, so the difference cannot underflow.
                            if ((trail_q[s] - h[s]) > HW'(DRAIN_STEP)) begin
                                trail_d[s] = trail_q[s] - HW'(DRAIN_STEP);
                            end else begin
                                trail_d[s] = h[s];
                                st_d[s]    = ST_IDLE;
                            end
                        end
                        default: st_d[s] = ST_IDLE;
                    endcase
                end
                if (h[s] == '0 && trail_d[s] == '0)
                    ko_d[s] = 1'b1;
                else if (h[s] != '0)
                    ko_d[s] = 1'b0;
            end
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (!any_ko) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

`ifdef LOW_HEALTH_FLASH_EN
    logic [BLK_W-1:0] lh_cnt_q, lh_cnt_d;
    logic             lh_phase_q, lh_phase_d;

    always_comb begin
        lh_cnt_d   = lh_cnt_q;
        lh_phase_d = lh_phase_q;
        if (tick) begin
            if (lh_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
                lh_cnt_d   = '0;
                lh_phase_d = ~lh_phase_q;
            end else begin
                lh_cnt_d = lh_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lh_cnt_q   <= '0;
            lh_phase_q <= 1'b0;
        end else begin
            lh_cnt_q   <= lh_cnt_d;
            lh_phase_q <= lh_phase_d;
        end
    end

    assign lh_phase = lh_phase_q;
`else
    assign lh_phase = 1'b0;
`endif

    always_comb begin
        px      = pixel_index % 13'd96;
        py      = pixel_index / 13'd96;
        in_rows = (py >= 13'(BAR_Y)) && (py < 13'(BAR_Y + BAR_H));
        side    = 1'b0;
        bar_i   = '0;
        in_bar  = 1'b0;
        if (px >= 13'd54 && px < 13'(54 + BAR_LEN)) begin
            side   = 1'b1;
            bar_i  = px - 13'd54;
            in_bar = in_rows;
        end else if (px <= 13'd41 && (px + 13'(BAR_LEN)) >= 13'd42) begin
            side   = 1'b0;
            bar_i  = 13'd41 - px;
            in_bar = in_rows;
        end
        oled_d = 16'h0000;
        if (px >= 13'd42 && px <= 13'd53 && py >= 13'd2 && py <= 13'd9) begin
            oled_d = (any_ko && blink_q && ko_glyph(px, py)) ? C_WHITE : C_RED;
        end else if (in_bar) begin
            if (bar_i < fill(h[side]))
                oled_d = (lh_phase && h[side] != '0 && h[side] <= HW'(MAX_HEALTH / 4)) ? C_WHITE : C_YELLOW;
            else if (bar_i < fill(trail_q[side]))
                oled_d = C_RED;
            else
                oled_d = C_GREY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            ko_q        <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            oled_q      <= 16'h0000;
            for (int s = 0; s < 2; s++) begin
                st_q[s]    <= ST_IDLE;
                trail_q[s] <= HW'(MAX_HEALTH);
                hprev_q[s] <= HW'(MAX_HEALTH);
                hold_q[s]  <= '0;
            end
        end else begin
            div_q       <= div_d;
            ko_q        <= ko_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            oled_q      <= oled_d;
            for (int s = 0; s < 2; s++) begin
                st_q[s]    <= st_d[s];
                trail_q[s] <= trail_d[s];
                hprev_q[s] <= hprev_d[s];
                hold_q[s]  <= hold_d[s];
            end
        end
    end

    assign oled_colour    = oled_q;
    assign final_health_l = trail_q[0];
    assign final_health_r = trail_q[1];
    assign ko_l           = ko_q[0];
    assign ko_r           = ko_q[1];
    assign anim_busy      = (st_q[0] != ST_IDLE) || (st_q[1] != ST_IDLE);
endmodule

// File: tb/tb_health_bar_animator.sv
// Self-checking bench for health_bar_animator: directed scenarios plus randomized health/pixel stimulus vs a behavioural model.
module tb_health_bar_animator;
    localparam int CLK_DIV = 4;
    localparam int MAXH    = 300;
    localparam logic [15:0] WHITE = 16'hFFFF, RED = 16'hF800, YELLOW = 16'hFFE0, GREY = 16'h2104;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  curr_health_l = 9'd300;
    logic [8:0]  curr_health_r = 9'd300;
    logic [12:0] pixel_index = 13'd0;
    logic [15:0] oled_colour;
    logic [8:0]  final_health_l, final_health_r;
    logic        ko_l, ko_r, anim_busy;

    int n_pass = 0, n_total = 0, n_fail = 0;
    bit chk_on = 1'b0;

    health_bar_animator #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .curr_health_l(curr_health_l), .curr_health_r(curr_health_r),
        .pixel_index(pixel_index), .oled_colour(oled_colour),
        .final_health_l(final_health_l), .final_health_r(final_health_r),
        .ko_l(ko_l), .ko_r(ko_r), .anim_busy(anim_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: trail per side, hold countdown, drain flag, KO, blink.
    int  m_t [2], n_t [2], m_hold [2], n_hold [2], m_hp [2], n_hp [2], hh [2];
    bit  m_holding [2], n_holding [2], m_drain [2], n_drain [2], m_ko [2], n_ko [2];
    int  m_bc, n_bc, m_div, n_div, m_ticks = 0, n_ticks;
    bit  m_ph, n_ph, m_tick;
    logic [15:0] m_oled, n_oled;

    function automatic int clampi(input logic [8:0] v);
        return (int'(v) > MAXH) ? MAXH : int'(v);
    endfunction

    function automatic logic [15:0] colour(input int idx, input int hl, input int hr,
                                           input int tl, input int tr, input bit ko, input bit ph);
        int x, y, i, h, t, col;
        string g;
        x = idx % 96;
        y = idx / 96;
        if (x >= 42 && x <= 53 && y >= 2 && y <= 9) begin
            if (ko && ph && y >= 3 && y <= 8 && x >= 43 && x <= 52) begin
                case (y)
                    3: g = "10001_01110";
                    4: g = "10010_10001";
                    5: g = "11100_10001";
                    6: g = "11100_10001";
                    7: g = "10010_10001";
                    default: g = "10001_01110";
                endcase
                col = x - 43;
                if (col >= 5) col = col + 1;
                if (g[col] == "1") return WHITE;
            end
            return RED;
        end
        if (y < 2 || y > 6) return 16'h0000;
        if (x >= 54 && x <= 93) begin
            i = x - 54; h = hr; t = tr;
        end else if (x >= 2 && x <= 41) begin
            i = 41 - x; h = hl; t = tl;
        end else begin
            return 16'h0000;
        end
        if (i < h * 40 / MAXH) return YELLOW;
        if (i < t * 40 / MAXH) return RED;
        return GREY;
    endfunction

    always_comb begin
        n_t = m_t; n_hold = m_hold; n_hp = m_hp; n_holding = m_holding; n_drain = m_drain;
        n_ko = m_ko; n_bc = m_bc; n_ph = m_ph; n_ticks = m_ticks;
        hh[0] = clampi(curr_health_l);
        hh[1] = clampi(curr_health_r);
        m_tick = (m_div == CLK_DIV - 1);
        n_div = m_tick ? 0 : m_div + 1;
        n_oled = colour(int'(pixel_index), hh[0], hh[1], m_t[0], m_t[1], m_ko[0] | m_ko[1], m_ph);
        if (m_tick) begin
            n_ticks = m_ticks + 1;
            for (int s = 0; s < 2; s++) begin
                n_hp[s] = hh[s];
                if (hh[s] > m_t[s]) begin
                    n_t[s] = hh[s]; n_holding[s] = 1'b0; n_drain[s] = 1'b0;
                end else if (m_drain[s]) begin
                    n_t[s] = (m_t[s] - 2 > hh[s]) ? m_t[s] - 2 : hh[s];
                    if (n_t[s] == hh[s]) n_drain[s] = 1'b0;
                end else if (m_holding[s]) begin
                    if (hh[s] < m_hp[s]) n_hold[s] = 9;
                    else if (m_hold[s] == 0) begin n_holding[s] = 1'b0; n_drain[s] = 1'b1; end
                    else n_hold[s] = m_hold[s] - 1;
                end else if (hh[s] < m_t[s]) begin
                    n_holding[s] = 1'b1; n_hold[s] = 9;
                end
                if (hh[s] == 0 && n_t[s] == 0) n_ko[s] = 1'b1;
                else if (hh[s] > 0) n_ko[s] = 1'b0;
            end
            if (m_ko[0] | m_ko[1]) begin
                n_bc = m_bc + 1;
                if (n_bc == 5) begin n_bc = 0; n_ph = !m_ph; end
            end else begin
                n_bc = 0; n_ph = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                m_t[s] <= MAXH; m_hold[s] <= 0; m_hp[s] <= MAXH;
                m_holding[s] <= 1'b0; m_drain[s] <= 1'b0; m_ko[s] <= 1'b0;
            end
            m_bc <= 0; m_ph <= 1'b0; m_div <= 0; m_oled <= 16'h0000;
        end else begin
            m_t <= n_t; m_hold <= n_hold; m_hp <= n_hp; m_holding <= n_holding;
            m_drain <= n_drain; m_ko <= n_ko; m_bc <= n_bc; m_ph <= n_ph;
            m_div <= n_div; m_ticks <= n_ticks; m_oled <= n_oled;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("oled_colour", 32'(oled_colour), 32'(m_oled));
            check("final_health_l", 32'(final_health_l), 32'(m_t[0]));
            check("final_health_r", 32'(final_health_r), 32'(m_t[1]));
            check("ko_l", 32'(ko_l), 32'(m_ko[0]));
            check("ko_r", 32'(ko_r), 32'(m_ko[1]));
            check("anim_busy", 32'(anim_busy), 32'(m_holding[0] | m_drain[0] | m_holding[1] | m_drain[1]));
        end
    end

    // Wait until tick k (0-based, counted from base) has completed.
    task automatic wait_done(input int base, input int k);
        int guard, limit;
        guard = 0;
        limit = CLK_DIV * (base + k + 1 - m_ticks) + 8;
        while (m_ticks < base + k + 1 && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        if (m_ticks < base + k + 1) begin
            n_total++; n_fail++;
            $display("FAIL tick_wait: got %0d ticks required %0d", m_ticks, base + k + 1);
        end
    endtask

    task automatic pix(input string name, input int idx, input logic [15:0] exp);
        pixel_index = 13'(idx);
        @(negedge clk);
        check(name, 32'(oled_colour), 32'(exp));
    endtask

    initial begin
        int t0, whites;
        repeat (3) @(negedge clk);
        check("rst_final_l", 32'(final_health_l), 32'd300);
        check("rst_final_r", 32'(final_health_r), 32'd300);
        check("rst_oled", 32'(oled_colour), 32'd0);
        check("rst_ko", 32'({ko_l, ko_r}), 32'd0);
        check("rst_busy", 32'(anim_busy), 32'd0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        // Hit, then re-hit during hold at tick 5.
        curr_health_r = 9'd200; t0 = m_ticks;
        wait_done(t0, 0);
        check("hit_busy", 32'(anim_busy), 32'd1);
        check("hit_trail", 32'(final_health_r), 32'd300);
        wait_done(t0, 4);
        curr_health_r = 9'd150; curr_health_l = 9'd150;
        wait_done(t0, 5);
        pix("pix_r_x54y2", 246, YELLOW);
        pix("pix_r_x73y6", 649, YELLOW);
        pix("pix_r_x74y2", 266, RED);
        pix("pix_r_x93y6", 669, RED);
        pix("pix_r_x94y2", 286, 16'h0000);
        pix("pix_r_x54y7", 726, 16'h0000);
        pix("pix_l_x41y2", 233, YELLOW);
        pix("pix_l_x22y4", 406, YELLOW);
        pix("pix_l_x21y4", 405, RED);
        pix("pix_l_x2y2", 194, RED);
        pix("pix_l_x1y2", 193, 16'h0000);
        pix("pix_box_noko", 522, RED);
        wait_done(t0, 15);
        check("rehit_hold_end", 32'(final_health_r), 32'd300);
        wait_done(t0, 16);
        check("rehit_first_drain", 32'(final_health_r), 32'd298);
        wait_done(t0, 89);
        check("rehit_near_end", 32'(final_health_r), 32'd152);
        wait_done(t0, 90);
        check("rehit_end_r", 32'(final_health_r), 32'd150);
        check("rehit_end_l", 32'(final_health_l), 32'd150);
        check("rehit_idle", 32'(anim_busy), 32'd0);

        // Heal mid-drain.
        curr_health_r = 9'd300; t0 = m_ticks;
        wait_done(t0, 0);
        check("heal_snap", 32'(final_health_r), 32'd300);
        curr_health_r = 9'd200; t0 = m_ticks;
        wait_done(t0, 40);
        check("drain_240", 32'(final_health_r), 32'd240);
        check("drain_busy", 32'(anim_busy), 32'd1);
        curr_health_r = 9'd260;
        wait_done(t0, 41);
        check("heal_260", 32'(final_health_r), 32'd260);
        check("heal_idle", 32'(anim_busy), 32'd0);

        // KO on the left, blink, then round restart.
        curr_health_l = 9'd0; t0 = m_ticks;
        wait_done(t0, 84);
        check("ko_pre", 32'(ko_l), 32'd0);
        check("ko_pre_trail", 32'(final_health_l), 32'd2);
        wait_done(t0, 85);
        check("ko_set", 32'(ko_l), 32'd1);
        check("ko_trail", 32'(final_health_l), 32'd0);
        pixel_index = 13'd331;
        whites = 0;
        for (int k = 86; k < 106; k++) begin
            wait_done(t0, k);
            if (oled_colour == WHITE) whites++;
        end
        check("ko_blink_white_ticks", 32'(whites), 32'd10);
        curr_health_l = 9'd300; t0 = m_ticks;
        wait_done(t0, 0);
        check("ko_clear", 32'(ko_l), 32'd0);
        check("ko_restart_trail", 32'(final_health_l), 32'd300);

        // Randomized phase with one asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            pixel_index = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(0, 6143))
                                                      : 13'($urandom_range(0, 959));
            if ($urandom_range(0, 149) == 0)
                curr_health_l = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
            if ($urandom_range(0, 149) == 0)
                curr_health_r = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
            if (c == 1500) begin
                #2 rst_n = 1'b0;
            end
            if (c == 1502) begin
                check("midrst_busy", 32'(anim_busy), 32'd0);
                check("midrst_trail", 32'(final_health_l), 32'd300);
            end
            if (c == 1503) rst_n = 1'b1;
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule
